// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NREQ writeback sources.
// Grants are combinational; the selected write is registered and drives the register file one cycle later.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*AW-1:0] i_req_rd,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic               i_wr_hold,
  output logic               o_rf_we,
  output logic [AW-1:0]      o_rf_rd,
  output logic [DW-1:0]      o_rf_wdata,
  output logic               o_busy,
  output logic [PW-1:0]      o_dbg_ptr
);

  // Handshake: requester i transfers rd/wdata on a posedge where i_req_valid[i] and
  // o_req_ready[i] are both high; it must hold valid/rd/wdata stable until then.

  logic [PW-1:0]   r_ptr;
  logic            r_rf_we;
  logic [AW-1:0]   r_rf_rd;
  logic [DW-1:0]   r_rf_wdata;
  logic            r_busy;

  logic [NREQ-1:0] w_grant;
  logic            w_any;
  logic [PW-1:0]   w_gidx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [AW-1:0]   w_sel_rd;
  logic [DW-1:0]   w_sel_wdata;
  int              w_idx;

  // Search starts at the pointer and wraps; grants are suppressed while in reset or on hold.
  always_comb begin
    w_grant = '0;
    w_any   = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_any && rst_n && !i_wr_hold && i_req_valid[PW'(w_idx)]) begin
        w_any  = 1'b1;
        w_gidx = PW'(w_idx);
      end
    end
    if (w_any) w_grant[w_gidx] = 1'b1;
  end

  always_comb begin
    w_ptr_nxt   = (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    w_sel_rd    = i_req_rd[w_gidx*AW +: AW];
    w_sel_wdata = i_req_wdata[w_gidx*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= |(i_req_valid & ~w_grant);
      if (w_any) begin
        r_ptr      <= w_ptr_nxt;
        r_rf_rd    <= w_sel_rd;
        r_rf_wdata <= w_sel_wdata;
        // Writes to x0 complete the handshake but never reach the register file.
        r_rf_we    <= |w_sel_rd;
      end else begin
        r_rf_we <= 1'b0;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_rf_we     = r_rf_we;
  assign o_rf_rd     = r_rf_rd;
  assign o_rf_wdata  = r_rf_wdata;
  assign o_busy      = r_busy;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus a randomized run against a
// round-robin reference model and an expected-write queue.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] v = '0;
  logic [AW-1:0]   rd [NREQ];
  logic [DW-1:0]   wd [NREQ];
  logic            hold = 1'b0;

  logic [NREQ-1:0] o_req_ready;
  logic            o_rf_we;
  logic [AW-1:0]   o_rf_rd;
  logic [DW-1:0]   o_rf_wdata;
  logic            o_busy;
  logic [1:0]      o_dbg_ptr;

  int total = 0;
  int bad = 0;

  // reference model state
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_wdata;
  logic          m_busy;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req_valid(v),
    .i_req_rd({rd[2], rd[1], rd[0]}),
    .i_req_wdata({wd[2], wd[1], wd[0]}),
    .o_req_ready(o_req_ready),
    .i_wr_hold(hold),
    .o_rf_we(o_rf_we),
    .o_rf_rd(o_rf_rd),
    .o_rf_wdata(o_rf_wdata),
    .o_busy(o_busy),
    .o_dbg_ptr(o_dbg_ptr)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [NREQ-1:0] model_grant();
    logic [NREQ-1:0] g;
    g = '0;
    if (!hold && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g == '0 && v[(m_ptr + k) % NREQ]) g[(m_ptr + k) % NREQ] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_rd = '0; m_wdata = '0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic tick();
    logic [NREQ-1:0] g;
    g = model_grant();
    @(posedge clk);
    m_busy = |(v & ~g);
    m_we = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        m_rd = rd[i];
        m_wdata = wd[i];
        m_we = (rd[i] != 0);
        m_ptr = (i + 1) % NREQ;
        if (rd[i] != 0) exp_q.push_back({rd[i], wd[i]});
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  // Scoreboard: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && o_rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_write got rd=%0d wdata=%h expected no write", o_rf_rd, o_rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_rf_rd, o_rf_wdata} !== mon_e) begin
          bad++;
          $display("FAIL sb_write got rd=%0d wdata=%h expected rd=%0d wdata=%h",
                   o_rf_rd, o_rf_wdata, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    v = 3'b111;
    for (int i = 0; i < NREQ; i++) begin rd[i] = AW'(i + 1); wd[i] = 32'h100 + i; end
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({o_rf_we, o_req_ready, o_busy, o_rf_rd, o_rf_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got we=%b ready=%b busy=%b rd=%0d wdata=%h expected all zero",
               o_rf_we, o_req_ready, o_busy, o_rf_rd, o_rf_wdata);
    end
    #2;
    rst_n = 1'b1;
    #1;
    total++;
    if (o_req_ready !== 3'b001) begin
      bad++; $display("FAIL reset_first_grant got=%b expected=001", o_req_ready);
    end
    v = '0;
    #1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    v = 3'b010; rd[1] = 5'd7; wd[1] = 32'hDEADBEEF;
    #1;
    total++;
    if (o_req_ready !== 3'b010) begin
      bad++; $display("FAIL single_ready got=%b expected=010", o_req_ready);
    end
    tick();
    v = '0;
    total++;
    if (o_rf_we !== 1'b1 || o_rf_rd !== 5'd7 || o_rf_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_write got we=%b rd=%0d wdata=%h expected we=1 rd=7 wdata=deadbeef",
               o_rf_we, o_rf_rd, o_rf_wdata);
    end
    tick();
    total++;
    if (o_rf_we !== 1'b0) begin
      bad++; $display("FAIL single_we_drop got=%b expected=0", o_rf_we);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_g;
    apply_reset();
    v = 3'b111;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        rd[i] = AW'($urandom_range(1, 31)); wd[i] = $urandom;
      end
      #1;
      exp_g = model_grant();
      total++;
      if (o_req_ready !== exp_g || exp_g !== NREQ'(1 << (c % 3))) begin
        bad++;
        $display("FAIL fair_grant cycle=%0d got=%b expected=%b", c, o_req_ready, exp_g);
      end
      tick();
      total++;
      if (o_rf_we !== 1'b1 || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL fair_we_busy cycle=%0d got we=%b busy=%b expected we=1 busy=1", c, o_rf_we, o_busy);
      end
    end
    v = '0;
  endtask

  task automatic test_x0();
    v = 3'b100; rd[2] = '0; wd[2] = 32'h55;
    #1;
    total++;
    if (o_req_ready !== 3'b100) begin
      bad++; $display("FAIL x0_ready got=%b expected=100", o_req_ready);
    end
    tick();
    total++;
    if (o_rf_we !== 1'b0) begin
      bad++; $display("FAIL x0_we got=%b expected=0", o_rf_we);
    end
    v = 3'b111; rd[0] = 5'd3; rd[1] = 5'd4; rd[2] = 5'd5;
    #1;
    total++;
    if (o_req_ready !== 3'b001) begin
      bad++; $display("FAIL x0_next_grant got=%b expected=001", o_req_ready);
    end
    v = '0;
    tick();
  endtask

  task automatic test_hold();
    logic [NREQ-1:0] g_before;
    v = 3'b111;
    for (int i = 0; i < NREQ; i++) begin rd[i] = AW'(10 + i); wd[i] = 32'hA0 + i; end
    #1;
    tick();
    g_before = model_grant();
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (o_req_ready !== '0) begin
        bad++; $display("FAIL hold_ready cycle=%0d got=%b expected=000", c, o_req_ready);
      end
      tick();
      total++;
      if (o_rf_we !== 1'b0 || int'(o_dbg_ptr) != m_ptr || o_busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_state cycle=%0d got we=%b ptr=%0d busy=%b expected we=0 ptr=%0d busy=1",
                 c, o_rf_we, o_dbg_ptr, o_busy, m_ptr);
      end
    end
    hold = 1'b0;
    #1;
    total++;
    if (o_req_ready !== g_before) begin
      bad++; $display("FAIL hold_release got=%b expected=%b", o_req_ready, g_before);
    end
    v = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    v = 3'b010; rd[1] = 5'd9; wd[1] = 32'hCAFE0001;
    #1;
    tick();
    total++;
    if (o_rf_we !== 1'b1) begin
      bad++; $display("FAIL mid_pre_we got=%b expected=1", o_rf_we);
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (o_rf_we !== 1'b0 || o_req_ready !== '0) begin
      bad++; $display("FAIL mid_reset got we=%b ready=%b expected we=0 ready=000", o_rf_we, o_req_ready);
    end
    v = 3'b111;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    total++;
    if (o_req_ready !== 3'b001) begin
      bad++; $display("FAIL mid_restart got=%b expected=001", o_req_ready);
    end
    v = '0;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g;
    apply_reset();
    for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      g = model_grant();
      total++;
      if (o_req_ready !== g) begin
        bad++; $display("FAIL rand_ready cycle=%0d got=%b expected=%b", c, o_req_ready, g);
      end
      tick();
      total++;
      if (o_rf_we !== m_we || (m_we && (o_rf_rd !== m_rd || o_rf_wdata !== m_wdata)) ||
          o_busy !== m_busy || int'(o_dbg_ptr) != m_ptr) begin
        bad++;
        $display("FAIL rand_state cycle=%0d got we=%b rd=%0d wd=%h busy=%b ptr=%0d expected we=%b rd=%0d wd=%h busy=%b ptr=%0d",
                 c, o_rf_we, o_rf_rd, o_rf_wdata, o_busy, o_dbg_ptr, m_we, m_rd, m_wdata, m_busy, m_ptr);
      end
      // Requesters only change once accepted (or when idle).
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] || !v[i]) begin
          v[i] = ($urandom_range(0, 99) < 60);
          rd[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
          wd[i] = $urandom;
        end
      end
      hold = ($urandom_range(0, 9) == 0);
      #1;
    end
    hold = 1'b0;
    v = '0;
    #1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin rd[i] = '0; wd[i] = '0; end
    test_reset();
    test_single();
    test_fairness();
    test_x0();
    test_hold();
    test_reset_mid();
    test_random();
    tick();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
